// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM state names and flag bit positions.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_NOR  = 3'b000,
    OP_NAND = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_XOR  = 3'b110,
    OP_SLT  = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    ST_WAIT_A  = 2'd0,
    ST_WAIT_B  = 2'd1,
    ST_WAIT_OP = 2'd2,
    ST_SHOW    = 2'd3
  } state_t;

  localparam int FLAG_V = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_P = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational N-bit ALU: eight operations plus {V,C,Z,N,P} flags.
module alu_core
  import alu_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   op,
  output logic [N-1:0] r,
  output logic [4:0]   flags
);

  // One extra bit so bit N carries the carry-out (add) or the borrow (sub).
  logic [N:0] sum;
  logic [N:0] diff;
  logic       v;
  logic       c;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    r = '0;
    v = 1'b0;
    c = 1'b0;
    case (op)
      OP_NOR:  r = ~(a | b);
      OP_NAND: r = ~(a & b);
      OP_ADD: begin
        r = sum[N-1:0];
        c = sum[N];
        v = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      OP_SUB: begin
        r = diff[N-1:0];
        c = diff[N];
        v = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      default: r = '0;
    endcase

    flags         = '0;
    flags[FLAG_V] = v;
    flags[FLAG_C] = c;
    flags[FLAG_Z] = (r == '0);
    flags[FLAG_N] = r[N-1];
    flags[FLAG_P] = ~r[0];
  end

endmodule

// File: rtl/alu_seq_fsm.sv
// Sequential ALU: A, B and opcode entered one per Enter press; result and flags held for display.
// Optional ALU_CHAIN_EN: an Enter in SHOW reloads A from the result and skips to WAIT_B.
module alu_seq_fsm
  import alu_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] data_in,
  input  logic [2:0]   op_in,
  input  logic         enter,
  input  logic         clear,
  output logic [N-1:0] result,
  output logic [4:0]   flags,
  output logic [1:0]   state_out,
  output logic         done
);

  localparam logic [1:0] S_WAIT_A  = ST_WAIT_A;
  localparam logic [1:0] S_WAIT_B  = ST_WAIT_B;
  localparam logic [1:0] S_WAIT_OP = ST_WAIT_OP;
  localparam logic [1:0] S_SHOW    = ST_SHOW;

  logic [1:0]   state;
  logic         enter_q;
  logic         ent;
  logic [N-1:0] a_reg;
  logic [N-1:0] b_reg;
  logic [N-1:0] alu_r;
  logic [4:0]   alu_flags;

  // enter is a level; ent fires only on its rising edge. clear beats ent in the
  // same cycle; done is a single-cycle pulse marking a freshly registered result.
  assign ent       = enter & ~enter_q;
  assign state_out = state;

  alu_core #(.N(N)) u_core (
    .a     (a_reg),
    .b     (b_reg),
    .op    (op_in),
    .r     (alu_r),
    .flags (alu_flags)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_WAIT_A;
      enter_q <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      result  <= '0;
      flags   <= '0;
      done    <= 1'b0;
    end else begin
      enter_q <= enter;
      done    <= 1'b0;
      if (clear) begin
        state <= S_WAIT_A;
      end else if (ent) begin
        case (state)
          S_WAIT_A: begin
            a_reg <= data_in;
            state <= S_WAIT_B;
          end
          S_WAIT_B: begin
            b_reg <= data_in;
            state <= S_WAIT_OP;
          end
          S_WAIT_OP: begin
            result <= alu_r;
            flags  <= alu_flags;
            done   <= 1'b1;
            state  <= S_SHOW;
          end
          S_SHOW: begin
`ifdef ALU_CHAIN_EN
            a_reg <= result;
            state <= S_WAIT_B;
`else
            state <= S_WAIT_A;
`endif
          end
          default: state <= S_WAIT_A;
        endcase
      end
    end
  end

endmodule
